// File: rtl/cell_stream_ctrl_if.sv
// Bundle of the stream request, write request and cell memory signals.
// The controller takes the slave view; the surrounding system takes the master view.
interface cell_stream_ctrl_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_start;
    logic                  rd_stall;
    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_ack;
    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;
    logic [ADDR_WIDTH-1:0] particle_count;
    logic [DATA_WIDTH-1:0] pos_out;
    logic                  pos_valid;
    logic                  pos_last;
    logic                  busy;
    logic                  done;

    modport master (
        output rd_start, rd_stall, wr_req, wr_addr, wr_data, mem_q,
        input  wr_ack, mem_address, mem_data, mem_rden, mem_wren,
               particle_count, pos_out, pos_valid, pos_last, busy, done
    );

    modport slave (
        input  rd_start, rd_stall, wr_req, wr_addr, wr_data, mem_q,
        output wr_ack, mem_address, mem_data, mem_rden, mem_wren,
               particle_count, pos_out, pos_valid, pos_last, busy, done
    );
endinterface

// File: rtl/cell_stream_ctrl.sv
// Streams every position word of one cell memory (count at address 0, words at 1..count)
// and arbitrates single-word writes into the same memory while idle.
module cell_stream_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic               clk,
    input  logic               rst,
    cell_stream_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] MAX_ADDR = ADDR_WIDTH'(PARTICLE_NUM - 1);

    function automatic logic [ADDR_WIDTH-1:0] clamp_count(input logic [ADDR_WIDTH-1:0] raw);
        return (raw > MAX_ADDR) ? MAX_ADDR : raw;
    endfunction

    state_t                state_q;
    logic                  pend_q;
    logic                  wait_q;
    logic                  wr_ack_q;
    logic [ADDR_WIDTH-1:0] mem_address_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic                  mem_rden_q;
    logic                  mem_wren_q;
    logic [ADDR_WIDTH-1:0] particle_count_q;
    logic                  vld_p0_q;
    logic                  last_p0_q;
    logic                  vld_p1_q;
    logic                  last_p1_q;
    logic                  vld_p2_q;
    logic                  last_p2_q;
    logic [DATA_WIDTH-1:0] pos_out_q;
    logic                  pos_valid_q;
    logic                  pos_last_q;
    logic                  busy_q;
    logic                  done_q;

    logic [ADDR_WIDTH-1:0] cnt_d;
    logic [ADDR_WIDTH-1:0] tgt_d;
    logic [ADDR_WIDTH-1:0] next_addr_d;
    logic                  last_d;
    logic                  wr_grant_d;
    logic                  start_d;

    // The first data read is decided in the same cycle the count arrives, so the
    // target comes straight from the clamped memory word rather than the register.
    always_comb begin
        cnt_d       = clamp_count(bus.mem_q[ADDR_WIDTH-1:0]);
        tgt_d       = (state_q == WAIT_CNT) ? cnt_d : particle_count_q;
        next_addr_d = mem_address_q + ADDR_WIDTH'(1);
        last_d      = (next_addr_d == tgt_d);
        wr_grant_d  = bus.wr_req && !wr_ack_q;
        start_d     = (bus.rd_start || pend_q) && !bus.wr_req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            pend_q           <= 1'b0;
            wait_q           <= 1'b0;
            wr_ack_q         <= 1'b0;
            mem_address_q    <= '0;
            mem_data_q       <= '0;
            mem_rden_q       <= 1'b0;
            mem_wren_q       <= 1'b0;
            particle_count_q <= '0;
            vld_p0_q         <= 1'b0;
            last_p0_q        <= 1'b0;
            vld_p1_q         <= 1'b0;
            last_p1_q        <= 1'b0;
            vld_p2_q         <= 1'b0;
            last_p2_q        <= 1'b0;
            pos_out_q        <= '0;
            pos_valid_q      <= 1'b0;
            pos_last_q       <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            wr_ack_q   <= 1'b0;
            mem_wren_q <= 1'b0;
            mem_rden_q <= 1'b0;
            vld_p0_q   <= 1'b0;
            last_p0_q  <= 1'b0;
            done_q     <= 1'b0;

            // p0: read issued this cycle; p1/p2: memory latency; then output register
            vld_p1_q    <= vld_p0_q;
            last_p1_q   <= last_p0_q;
            vld_p2_q    <= vld_p1_q;
            last_p2_q   <= last_p1_q;
            pos_valid_q <= vld_p2_q;
            pos_last_q  <= last_p2_q;
            if (vld_p2_q) begin
                pos_out_q <= bus.mem_q;
            end

            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        state_q       <= RD_CNT;
                        pend_q        <= 1'b0;
                        busy_q        <= 1'b1;
                        mem_address_q <= '0;
                        mem_rden_q    <= 1'b1;
                    end else begin
                        if (bus.rd_start) begin
                            pend_q <= 1'b1;
                        end
                        if (wr_grant_d) begin
                            wr_ack_q      <= 1'b1;
                            mem_wren_q    <= 1'b1;
                            mem_address_q <= bus.wr_addr;
                            mem_data_q    <= bus.wr_data;
                        end
                    end
                end
                RD_CNT: begin
                    state_q <= WAIT_CNT;
                    wait_q  <= 1'b0;
                end
                WAIT_CNT: begin
                    if (!wait_q) begin
                        wait_q <= 1'b1;
                    end else begin
                        particle_count_q <= cnt_d;
                        if (cnt_d == '0) begin
                            state_q <= DONE;
                        end else begin
                            state_q <= STREAM;
                            if (!bus.rd_stall) begin
                                mem_address_q <= next_addr_d;
                                mem_rden_q    <= 1'b1;
                                vld_p0_q      <= 1'b1;
                                last_p0_q     <= last_d;
                                if (last_d) begin
                                    state_q <= DRAIN;
                                end
                            end
                        end
                    end
                end
                STREAM: begin
                    if (!bus.rd_stall) begin
                        mem_address_q <= next_addr_d;
                        mem_rden_q    <= 1'b1;
                        vld_p0_q      <= 1'b1;
                        last_p0_q     <= last_d;
                        if (last_d) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The p2 word is captured this edge, so only p0/p1 still matter.
                    if (!vld_p0_q && !vld_p1_q) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.wr_ack         = wr_ack_q;
    assign bus.mem_address    = mem_address_q;
    assign bus.mem_data       = mem_data_q;
    assign bus.mem_rden       = mem_rden_q;
    assign bus.mem_wren       = mem_wren_q;
    assign bus.particle_count = particle_count_q;
    assign bus.pos_out        = pos_out_q;
    assign bus.pos_valid      = pos_valid_q;
    assign bus.pos_last       = pos_last_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
endmodule

// File: doc/cell_stream_ctrl.md
CELL_STREAM_CTRL -- requirements
Module: cell_stream_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 96, meaning the position word width {posz, posy, posx}, 32 bits each.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the cell memory address width.
REQ-003 The block SHALL have parameter PARTICLE_NUM, default 220, meaning the cell memory depth in words, including the count word at address 0.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset: clock  in  1  rising-edge clock for all logic.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 rd_start  in  1  one-cycle request to stream the whole cell.
REQ-007 rd_stall  in  1  while high, no new read is issued.
REQ-008 wr_req  in  1  write request, held until acknowledged.
REQ-009 wr_addr  in  ADDR_WIDTH  write address.
REQ-010 wr_data  in  DATA_WIDTH  write data.
REQ-011 wr_ack  out  1  one-cycle grant; the write is issued in this cycle.
REQ-012 mem_address  out  ADDR_WIDTH  cell memory address.
REQ-013 mem_data  out  DATA_WIDTH  cell memory write data.
REQ-014 mem_rden  out  1  cell memory read enable.
REQ-015 mem_wren  out  1  cell memory write enable.
REQ-016 mem_q  in  DATA_WIDTH  cell memory read data, valid 2 cycles after the address.
REQ-017 particle_count  out  ADDR_WIDTH  particle count captured from address 0.
REQ-018 pos_out  out  DATA_WIDTH  streamed position word.
REQ-019 pos_valid  out  1  pos_out is valid.
REQ-020 pos_last  out  1  marks the final streamed word.
REQ-021 busy  out  1  a stream is in progress.
REQ-022 done  out  1  one-cycle stream-complete pulse.

Function
REQ-023 All outputs SHALL be registered.
REQ-024 The FSM states SHALL be IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN and DONE.
REQ-025 IDLE, wr_req high: the block SHALL assert wr_ack and drive mem_wren=1, mem_address=wr_addr and mem_data=wr_data in the next cycle, and mem_rden SHALL be 0 in that cycle.
REQ-026 Writes SHALL be granted only in IDLE; in any other state wr_ack SHALL stay 0 and the requester holds.
REQ-027 rd_start while in IDLE with wr_req high SHALL set a pending flag, the write SHALL win, and the stream SHALL start on the first IDLE cycle with no wr_req.
REQ-028 rd_start outside IDLE SHALL be ignored.
REQ-029 Stream start (rd_start or pending flag, IDLE, no wr_req sampled in cycle 0): the block SHALL enter RD_CNT and drive mem_address=0, mem_rden=1 in cycle 1.
REQ-030 The block SHALL then move to WAIT_CNT and capture mem_q[ADDR_WIDTH-1:0] in cycle 3, so particle_count is valid from cycle 4.
REQ-031 A captured count greater than PARTICLE_NUM-1 SHALL be clamped to PARTICLE_NUM-1.
REQ-032 Count 0: the block SHALL skip STREAM and DRAIN, enter DONE in cycle 4, and assert no pos_valid.
REQ-033 STREAM SHALL issue reads to addresses 1..count in order, one per cycle, starting cycle 4, with mem_rden=1 only on issue cycles.
REQ-034 While rd_stall is high, STREAM SHALL issue no read and SHALL hold the address.
REQ-035 A 2-deep valid shift register SHALL track in-flight reads so that reads issued before a stall still return.
REQ-036 The word read at cycle t SHALL appear on pos_out with pos_valid=1 at cycle t+3 (2 cycles memory latency plus 1 output register).
REQ-037 pos_last SHALL be 1 only together with the word from address count.
REQ-038 After issuing address count, the block SHALL enter DRAIN until no reads are in flight and the last word is output, then enter DONE.
REQ-039 DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-040 busy SHALL be 1 in RD_CNT, WAIT_CNT, STREAM, DRAIN and DONE.
REQ-041 mem_rden and mem_wren SHALL never both be 1 in the same cycle.
REQ-042 Address arithmetic SHALL be ADDR_WIDTH unsigned and SHALL never exceed PARTICLE_NUM-1.

Reset
REQ-043 rst SHALL put the FSM in IDLE and clear the pending flag and valid pipeline.
REQ-044 After rst, all outputs SHALL be 0, including particle_count, pos_out, wr_ack, mem_address and mem_data.
REQ-045 rst asserted mid-stream SHALL abort the stream, suppress in-flight data, and assert no done.

Verification
REQ-046 Memory word 0 = 3, rd_start in cycle 0 -> mem_rden at address 0 in cycle 1; particle_count = 3 from cycle 4; reads issued cycles 4-6; pos_valid in cycles 7-9 with addresses 1-3 data; pos_last in cycle 9; done in cycle 10.
REQ-047 Word 0 = 0 -> no pos_valid; done in cycle 5.
REQ-048 Word 0 = 3, rd_stall high for cycle 5 -> reads issued cycles 4, 6 and 7; pos_valid in cycles 7, 9 and 10; data order preserved.
REQ-049 rd_start and wr_req together in IDLE -> wr_ack plus write in the next cycle, then the stream starts; read-back returns the new word.
REQ-050 wr_req held during a stream -> wr_ack stays 0 until IDLE, then the write is granted.
REQ-051 rst asserted in cycle 8 of an N=5 stream -> all outputs are 0 from cycle 9; no done pulse; a new rd_start works normally.
